// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dice_pkg
// Purpose  : Die codes, side-count lookup and sequencer state type shared by
//            the dice roll arbiter and its testbench.
// Revision : 1.0
// ============================================================================
package dice_pkg;

    localparam logic [1:0] DIE_D4  = 2'b00;
    localparam logic [1:0] DIE_D6  = 2'b01;
    localparam logic [1:0] DIE_D8  = 2'b10;
    localparam logic [1:0] DIE_D20 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ROLL    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESULT  = 3'd5
    } state_t;

    function automatic logic [7:0] die_sides(input logic [1:0] code);
        case (code)
            DIE_D4:  return 8'd4;
            DIE_D6:  return 8'd6;
            DIE_D8:  return 8'd8;
            default: return 8'd20;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick; the search starts just after the
//            last granted index and wraps around.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dice_roll_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dice_roll_arbiter
// Purpose  : Shares one dice_roller among N_REQ requesters: round-robin grant,
//            fixed roll/settle sequencing, range-checked result handshake.
// Revision : 1.0
// ============================================================================
module dice_roll_arbiter
    import dice_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int ROLL_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       req_die,
    output logic [N_REQ-1:0]         gnt,
    output logic [1:0]               dr_die_select,
    output logic                     dr_roll,
    input  logic [7:0]               dr_rolled_number,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [7:0]               res_number,
    output logic                     res_err,
    output logic                     busy
);

    localparam int IDW     = $clog2(N_REQ);
    localparam int CNT_MAX = (ROLL_CYCLES > SETTLE_CYCLES) ? ROLL_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   id_q;
    logic [N_REQ-1:0] gnt_q;
    logic [1:0]       die_q;
    logic             roll_q;
    logic             valid_q;
    logic [7:0]       number_q;
    logic             err_q;
    logic             busy_q;

    logic [N_REQ-1:0] arb_grant;
    logic [IDW-1:0]   arb_idx;
    logic [1:0]       arb_die;
    logic [7:0]       sides;
    logic             capture_err;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_die     = req_die[{arb_idx, 1'b0} +: 2];
    assign sides       = die_sides(die_q);
    assign capture_err = (dr_rolled_number == 8'd0) || (dr_rolled_number > sides);

    // Sequencer: gnt is a one-cycle pulse, everything else holds until changed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= IDW'(N_REQ - 1);
            id_q     <= '0;
            gnt_q    <= '0;
            die_q    <= DIE_D4;
            roll_q   <= 1'b0;
            valid_q  <= 1'b0;
            number_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            gnt_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_SETUP;
                        gnt_q   <= arb_grant;
                        last_q  <= arb_idx;
                        id_q    <= arb_idx;
                        die_q   <= arb_die;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_ROLL;
                    roll_q  <= 1'b1;
                    cnt_q   <= CW'(ROLL_CYCLES - 1);
                end
                ST_ROLL: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SETTLE;
                        roll_q  <= 1'b0;
                        cnt_q   <= CW'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    state_q  <= ST_RESULT;
                    number_q <= dr_rolled_number;
                    err_q    <= capture_err;
                    valid_q  <= 1'b1;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    roll_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign dr_die_select = die_q;
    assign dr_roll       = roll_q;
    assign res_valid     = valid_q;
    assign res_id        = id_q;
    assign res_number    = number_q;
    assign res_err       = err_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: doc/dice_roll_arbiter.md
# dice_roll_arbiter

Shares one `dice_roller` instance among `N_REQ` requesters. Each requester asks for a roll of a selected die. The block arbitrates round-robin and sequences the roller's `die_select`/`roll` inputs with fixed timing. It then captures and range-checks `rolled_number` and returns the result through a valid/ready handshake tagged with the requester id. It sits directly in front of `dice_roller`, which is instantiated alongside it at the same level.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `ROLL_CYCLES`, 10, cycles `dr_roll` is held high per roll (≥1).
- `SETTLE_CYCLES`, 2, cycles after `dr_roll` falls before capture (≥1).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-requester roll request, level, held until granted.
- `req_die`  in  2*N_REQ  die code per requester, slice i = bits [2i+1:2i]: 00=d4, 01=d6, 10=d8, 11=d20.
- `gnt`  out  N_REQ  one-hot, one-cycle grant pulse.
- `dr_die_select`  out  2  to `dice_roller.die_select`.
- `dr_roll`  out  1  to `dice_roller.roll`.
- `dr_rolled_number`  in  8  from `dice_roller.rolled_number`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_id`  out  clog2(N_REQ)  requester that owns the result.
- `res_number`  out  8  captured roll value.
- `res_err`  out  1  captured value outside 1..sides.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, ROLL, SETTLE, CAPTURE, RESULT.
- IDLE: if `req`≠0 at an edge, choose the winner round-robin. Priority starts at `(last_granted+1) mod N_REQ`. Latch the id and `req_die` slice, then go to SETUP.
- SETUP, 1 cycle: `gnt[id]`=1, `dr_die_select`=latched die, `dr_roll`=0.
- ROLL, `ROLL_CYCLES` cycles: `dr_roll`=1.
- SETTLE, `SETTLE_CYCLES` cycles: `dr_roll`=0.
- CAPTURE, 1 cycle: register `res_number`←`dr_rolled_number` and set `res_err`=(value==0 or value>sides). Sides are 4/6/8/20, compared at 8 bits. Go to RESULT.
- RESULT: `res_valid`=1 with `res_id`/`res_number`/`res_err` stable. On `res_valid&&res_ready`, clear `res_valid` and go to IDLE. There is one bubble cycle before the next arbitration.
- `req` is ignored outside IDLE. A request dropped before it is sampled in IDLE is never granted.
- `dr_die_select` holds its last value in IDLE and RESULT. It is constant from SETUP through CAPTURE.
- Update `last_granted` on entry to SETUP.
- Reset mid-operation: the next edge forces IDLE and all reset values. Any pending result is discarded.
- Reset values: `gnt`=0, `dr_roll`=0, `dr_die_select`=00, `res_valid`=0, `res_id`=0, `res_number`=0, `res_err`=0, `busy`=0. `last_granted`=N_REQ-1, so requester 0 has first priority.

## Timing
- Let G be the SETUP cycle (the `gnt` pulse). `dr_roll` is high in cycles G+1 .. G+ROLL_CYCLES.
- CAPTURE is cycle G+ROLL_CYCLES+SETTLE_CYCLES+1. `res_valid` first rises at G+ROLL_CYCLES+SETTLE_CYCLES+2; with defaults that is G+14.
- Minimum spacing between grants is ROLL_CYCLES+SETTLE_CYCLES+4 cycles when `res_ready`=1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `dice_pkg`:
  - die-code constants `DIE_D4`/`DIE_D6`/`DIE_D8`/`DIE_D20`;
  - a `die_sides` function (code→8-bit side count);
  - the FSM state typedef.
- Sub-module `rr_arbiter` (parameter `N`): combinational inputs `req`, `last`; output one-hot `grant` plus encoded index.
- FSM, counters and capture stay in `dice_roll_arbiter`.

## Test plan
- Single request, d20, defaults:
  - after reset all outputs are 0;
  - `req[2]`=1 with die 11 → `gnt`=0100 for one cycle and `dr_die_select`=11;
  - `dr_roll` high exactly 10 cycles;
  - `res_valid` at G+14 with `res_id`=2, `res_number` in 1..20, `res_err`=0.
- Fairness: all four `req` held high, `res_ready`=1 → grant order 0,1,2,3,0,1. Each requester receives its own die code on `dr_die_select`.
- Backpressure: `res_ready`=0 for 20 cycles in RESULT → `res_valid`, `res_number` and `res_id` stay stable, no `gnt`, `dr_roll`=0. Raising `res_ready` gives a handshake and an IDLE bubble before the next `gnt`.
- Range check (bench model returns fixed values): d4 returning 0 → `res_err`=1; d4 returning 5 → `res_err`=1; d6 returning 6 → `res_err`=0; d20 returning 21 → `res_err`=1.
- Reset mid-roll: `reset`=0 in the 5th ROLL cycle → the next edge gives `dr_roll`=0, `busy`=0, and `res_valid` never rises. After release, with `req`=1010, `gnt`=0010 first.
- Pointer wrap: only `req[3]` is granted; then `req`=1001 → `gnt[0]` before `gnt[3]`.
